// File: rtl/mux_tt_scanner.sv
// rtl/mux_tt_scanner.sv - exhaustive truth-table scanner for a 4-input mux-based function
//
// Steps vec through 0..15, holds each vector for SETTLE_CYC cycles and then
// samples func_in into tt[vec].  After the last vector the captured table is
// compared against the EXPECTED parameter.
//
// Parameters
//   SETTLE_CYC : cycles each vector is held before it is sampled (1..15)
//   EXPECTED   : golden truth table, bit i = expected output for vector i
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : scan request, honoured only in IDLE
//   abort    : stops a scan in progress (SETTLE or SAMPLE)
//   func_in  : output of the function under control
//   vec      : function inputs {A,B,C,D}
//   busy     : scan in progress
//   done     : one-cycle pulse when a full scan completes
//   tt       : captured truth table
//   mismatch : tt differs from EXPECTED (updated with done)
//   err_cnt  : number of differing bits, 0..16 (updated with done)

module mux_tt_scanner #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [15:0] EXPECTED   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        func_in,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        mismatch,
    output logic [4:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [3:0] index;
    logic [3:0] settle_cnt;

    logic [15:0] tt_nxt;
    logic [4:0]  err_nxt;

    // Population count kept at 5 bits so that 16 differing bits reads as 16.
    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    // Table as it will look after the current SAMPLE write; the final
    // comparison uses this so mismatch/err_cnt are valid alongside done.
    always_comb begin
        tt_nxt        = tt;
        tt_nxt[index] = func_in;
        err_nxt       = popcnt16(tt_nxt ^ EXPECTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= 4'h0;
            settle_cnt <= 4'h0;
            vec        <= 4'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tt         <= 16'h0000;
            mismatch   <= 1'b0;
            err_cnt    <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        tt         <= 16'h0000;
                        index      <= 4'h0;
                        settle_cnt <= 4'h0;
                        vec        <= 4'h0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        index      <= 4'h0;
                        settle_cnt <= 4'h0;
                        vec        <= 4'h0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'h1;
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        // Captured bits are kept; this cycle's write is dropped.
                        index      <= 4'h0;
                        settle_cnt <= 4'h0;
                        vec        <= 4'h0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tt         <= tt_nxt;
                        settle_cnt <= 4'h0;
                        if (index == 4'hF) begin
                            vec      <= 4'h0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mismatch <= (tt_nxt != EXPECTED);
                            err_cnt  <= err_nxt;
                            state    <= DONE;
                        end else begin
                            index <= index + 4'h1;
                            vec   <= index + 4'h1;
                            state <= SETTLE;
                        end
                    end
                end

                DONE: begin
                    index <= 4'h0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
